i2c_temp_responder: RTL and testbench
=====================================

I2C_TEMP_RESPONDER -- requirements
Module: i2c_temp_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h4B, 7-bit target address the block answers to.
REQ-002 SHALL have port clk_100MHz  input  1  system clock; the single clock of the block.
REQ-003 SHALL have port reset_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port scl  input  1  I2C clock from the bus master, nominally 200 kHz.
REQ-005 SHALL have port sda_in  input  1  I2C data as sampled from the bus.
REQ-006 SHALL have port sda_oe  output  1  open-drain enable; 1 pulls SDA low, 0 releases it.
REQ-007 SHALL have port temp_data  input  16  register value returned to the master, MSB byte first.
REQ-008 SHALL have port rx_data  output  8  last byte written by the master.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-010 SHALL have port busy  output  1  high from an address match until STOP or the return to IDLE.

Function
REQ-011 SHALL pass scl and sda_in each through a 2-flop synchronizer; all bus decisions use the synchronized values and their registered previous values.
REQ-012 SHALL detect START as a synchronized SDA fall while synchronized SCL is high, and STOP as a synchronized SDA rise while synchronized SCL is high.
REQ-013 SHALL sample received bits on synchronized SCL rising edges and change sda_oe only on synchronized SCL falling edges.
REQ-014 SHALL use states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
REQ-015 IDLE -> ADDR on START.
REQ-016 ADDR: shift in 8 bits MSB first (7-bit address then R/W); after the 8th rising edge go to ADDR_ACK on a match, otherwise go to WAIT_STOP.
REQ-017 ADDR_ACK: drive sda_oe=1 from the falling edge after bit 8 until the next falling edge.
REQ-018 On a read (R/W=1), ADDR_ACK SHALL latch temp_data into a 16-bit shift register at that next falling edge, drive bit 15, and go to TX_BYTE.
REQ-019 On a write (R/W=0), ADDR_ACK SHALL release SDA at that next falling edge and go to RX_BYTE.
REQ-020 TX_BYTE: sda_oe = inverse of the current data bit; advance one bit per falling edge; after 8 bits release SDA and go to TX_ACK.
REQ-021 TX_ACK: sample the master's bit on the rising edge.
REQ-022 In TX_ACK, ACK (0) after the first byte SHALL continue with bits 7..0 of the latched value.
REQ-023 In TX_ACK, NACK, or any acknowledgement after the second byte, SHALL go to WAIT_STOP with SDA released.
REQ-024 RX_BYTE: shift in 8 bits; on the 8th rising edge update rx_data, pulse rx_valid for one clk_100MHz cycle, and go to RX_ACK.
REQ-025 RX_ACK: drive ACK (sda_oe=1) for one SCL period, then release and return to RX_BYTE; there is no limit on the number of write bytes.
REQ-026 WAIT_STOP: sda_oe=0; leave only on STOP (-> IDLE) or START (-> ADDR).
REQ-027 START detected in any state SHALL abort the current transfer, release SDA, and enter ADDR with the bit counter cleared (repeated start).
REQ-028 STOP detected in any state SHALL release SDA and enter IDLE; a partial received byte SHALL be discarded without an rx_valid pulse.
REQ-029 A change of temp_data after the latch SHALL NOT affect the bytes being sent.
REQ-030 busy SHALL be 1 in ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE and TX_ACK, and 0 otherwise.
REQ-031 The bit counter SHALL be 3 bits and wrap 7 -> 0 at each byte boundary.

Reset
REQ-032 While reset_n=0 at a rising clk_100MHz edge, the block SHALL set state=IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, busy=0, clear the shift registers and counter, and load the synchronizers with 1 (idle bus).
REQ-033 Reset asserted mid-transfer SHALL release SDA on the next clock edge; after release the block SHALL ignore the bus until the next START.

Verification
REQ-034 Read, temp_data=16'h0C80, master sends START, 0x97, ACKs byte 1, NACKs byte 2, STOP -> address ACKed, bytes 0x0C then 0x80 on SDA, final state IDLE.
REQ-035 Write of 0x96, 0x03, 0xA5 -> three ACKs; rx_valid pulses twice with rx_data 0x03 then 0xA5.
REQ-036 Address 0x90 (not a match) -> sda_oe stays 0 for the whole transfer, busy stays 0, block sits in WAIT_STOP until STOP.
REQ-037 Write 0x96, 0x01, then repeated START and 0x97 -> address ACKed again and temp_data returned with no intervening STOP.
REQ-038 temp_data changed to 16'hFFFF during byte 1 of a read of 16'h1234 -> master receives 0x12, 0x34.
REQ-039 reset_n=0 while the block drives ACK -> sda_oe=0 on the next clock edge; the following full read transaction completes correctly.

Source files
------------

// File: rtl/i2c_temp_responder.sv
// i2c_temp_responder
//   I2C target that answers at DEV_ADDR. A read returns temp_data as two
//   bytes, MSB byte first. The value is captured when the address is
//   acknowledged. A write accepts any number of bytes. Each byte is ACKed,
//   published on rx_data and flagged with a one-cycle rx_valid pulse.
//   Everything runs on clk_100MHz. SCL and SDA are oversampled.
// Ports
//   clk_100MHz  system clock
//   reset_n     synchronous active-low reset
//   scl         bus clock from the master
//   sda_in      bus data as seen on the wire
//   sda_oe      1 = pull SDA low, 0 = release
//   temp_data   16-bit value returned on reads
//   rx_data     last byte written by the master
//   rx_valid    one-cycle pulse when rx_data updates
//   busy        high while this target owns a transfer
module i2c_temp_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h4B
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_data,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX_BYTE   = 3'd3,
        RX_ACK    = 3'd4,
        TX_BYTE   = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    state_t      state, state_nxt;
    logic        scl_s1, scl_s2, scl_d;
    logic        sda_s1, sda_s2, sda_d;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_in;
    logic [15:0] tx_sr;
    logic        rw;
    logic        second;     // sending the LSB byte of the read
    logic        sda_oe_nxt;

    // Two-flop synchronizers, plus one more stage for edge detection.
    // They reset to 1 so that the block sees an idle bus.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
        end else begin
            scl_s1 <= scl;    scl_s2 <= scl_s1; scl_d <= scl_s2;
            sda_s1 <= sda_in; sda_s2 <= sda_s1; sda_d <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

    // State register
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic. START and STOP override every state.
    always_comb begin
        state_nxt = state;
        if (start_det)
            state_nxt = ADDR;
        else if (stop_det)
            state_nxt = IDLE;
        else begin
            case (state)
                ADDR:
                    // shift_in[6:0] already holds the 7 address bits at the 8th rise
                    if (scl_rise && bit_cnt == 3'd7)
                        state_nxt = (shift_in[6:0] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
                // sda_oe doubles as the phase flag: low means the ACK has not started yet
                ADDR_ACK:
                    if (scl_fall && sda_oe) state_nxt = rw ? TX_BYTE : RX_BYTE;
                RX_BYTE:
                    if (scl_rise && bit_cnt == 3'd7) state_nxt = RX_ACK;
                RX_ACK:
                    if (scl_fall && sda_oe) state_nxt = RX_BYTE;
                TX_BYTE:
                    if (scl_fall && bit_cnt == 3'd7) state_nxt = TX_ACK;
                TX_ACK:
                    // Entered on a fall, so the master's ACK rise always comes first
                    if (scl_rise && (sda_s2 || second)) state_nxt = WAIT_STOP;
                    else if (scl_fall)                  state_nxt = TX_BYTE;
                default: ;
            endcase
        end
    end

    // Output logic. SDA moves only on SCL falls, or is released on START/STOP.
    always_comb begin
        sda_oe_nxt = sda_oe;
        if (start_det || stop_det)
            sda_oe_nxt = 1'b0;
        else if (scl_fall) begin
            case (state)
                ADDR_ACK: sda_oe_nxt = sda_oe ? (rw & ~temp_data[15]) : 1'b1;
                RX_ACK:   sda_oe_nxt = ~sda_oe;
                TX_BYTE:  sda_oe_nxt = (bit_cnt == 3'd7) ? 1'b0 : ~tx_sr[14];
                TX_ACK:   sda_oe_nxt = ~tx_sr[15];
                default:  sda_oe_nxt = 1'b0;
            endcase
        end
        case (state)
            ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK: busy = 1'b1;
            default:                                   busy = 1'b0;
        endcase
    end

    // Datapath
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            bit_cnt  <= 3'd0;
            shift_in <= 8'h00;
            tx_sr    <= 16'h0000;
            rw       <= 1'b0;
            second   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            sda_oe   <= sda_oe_nxt;
            if (start_det || stop_det) begin
                bit_cnt  <= 3'd0;
                shift_in <= 8'h00;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shift_in <= {shift_in[6:0], sda_s2};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) rw <= sda_s2;
                    end
                    RX_BYTE: if (scl_rise) begin
                        shift_in <= {shift_in[6:0], sda_s2};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= {shift_in[6:0], sda_s2};
                            rx_valid <= 1'b1;
                        end
                    end
                    ADDR_ACK: if (scl_fall && sda_oe && rw) begin
                        tx_sr  <= temp_data;
                        second <= 1'b0;
                    end
                    // The 8th shift leaves bit 7 of the value in tx_sr[15], ready for byte 2
                    TX_BYTE: if (scl_fall) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        tx_sr   <= {tx_sr[14:0], 1'b0};
                    end
                    TX_ACK: if (scl_fall) second <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_temp_responder.sv
module tb_i2c_temp_responder;

    localparam int Q = 25;   // quarter SCL period in clk_100MHz cycles

    logic        clk_100MHz = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_oe;
    logic        sda_line;
    logic [15:0] temp_data = 16'h0000;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // Open-drain wired-AND of the master and the target
    assign sda_line = sda_m & ~sda_oe;

    always #5 clk_100MHz = ~clk_100MHz;

    i2c_temp_responder #(.DEV_ADDR(7'h4B)) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .scl        (scl_m),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .temp_data  (temp_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy)
    );

    // Bus monitor
    int         oe_cnt = 0, busy_cnt = 0, rx_cnt = 0, rx_long = 0;
    logic       rx_prev = 1'b0;
    logic [7:0] rx_log [64];
    always @(negedge clk_100MHz) begin
        if (sda_oe === 1'b1) oe_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (rx_valid === 1'b1) begin
            if (rx_cnt < 64) rx_log[rx_cnt] = rx_data;
            rx_cnt++;
            if (rx_prev) rx_long++;
        end
        rx_prev = (rx_valid === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_q;
        repeat (Q) @(posedge clk_100MHz);
        #1;
    endtask

    task automatic clock_bit(input logic b, output logic r);
        sda_m = b;    wait_q;
        scl_m = 1'b1; wait_q;
        r = sda_line; wait_q;
        scl_m = 1'b0; wait_q;
    endtask

    // Works both from an idle bus and as a repeated start with SCL low
    task automatic bus_start;
        sda_m = 1'b1; wait_q;
        scl_m = 1'b1; wait_q;
        sda_m = 1'b0; wait_q;
        scl_m = 1'b0; wait_q;
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; wait_q;
        scl_m = 1'b1; wait_q;
        sda_m = 1'b1; wait_q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
        clock_bit(1'b1, r);
        acked = ~r;
    endtask

    task automatic read_byte(input logic do_ack, input int chg_bit, input logic [15:0] chg_val,
                             output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            d[i] = r;
            if (7 - i == chg_bit) temp_data = chg_val;
        end
        clock_bit(~do_ack, r);
    endtask

    typedef struct {
        logic [7:0]  addr_byte;
        logic [15:0] temp;
        logic        exp_ack;
        logic [7:0]  exp_b1;
        logic [7:0]  exp_b2;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic       ack, ack2, ack3;
        logic [7:0] b1, b2;
        int         oe0, busy0, rx0;

        vecs[0] = '{8'h97, 16'h0C80, 1'b1, 8'h0C, 8'h80};
        vecs[1] = '{8'h97, 16'hFFFF, 1'b1, 8'hFF, 8'hFF};
        vecs[2] = '{8'h97, 16'h0001, 1'b1, 8'h00, 8'h01};
        vecs[3] = '{8'h90, 16'h1234, 1'b0, 8'hFF, 8'hFF};  // 0x48: not us

        // Reset state
        repeat (3) @(posedge clk_100MHz);
        #1;
        check("reset sda_oe",   32'(sda_oe),    32'h0);
        check("reset busy",     32'(busy),      32'h0);
        check("reset rx_data",  32'(rx_data),   32'h0);
        check("reset rx_valid", 32'(rx_valid),  32'h0);
        check("reset state",    32'(dut.state), 32'h0);
        @(negedge clk_100MHz) reset_n = 1'b1;
        wait_q;

        // Table-driven read transactions
        for (int i = 0; i < 4; i++) begin
            temp_data = vecs[i].temp;
            oe0 = oe_cnt; busy0 = busy_cnt;
            bus_start;
            write_byte(vecs[i].addr_byte, ack);
            check($sformatf("row%0d addr_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
            check($sformatf("row%0d state_after_addr", i), 32'(dut.state),
                  vecs[i].exp_ack ? 32'd5 : 32'd7);
            read_byte(1'b1, -1, 16'h0, b1);
            read_byte(1'b0, -1, 16'h0, b2);
            bus_stop;
            check($sformatf("row%0d byte1", i), 32'(b1), 32'(vecs[i].exp_b1));
            check($sformatf("row%0d byte2", i), 32'(b2), 32'(vecs[i].exp_b2));
            check($sformatf("row%0d busy_seen", i), 32'(busy_cnt != busy0), 32'(vecs[i].exp_ack));
            check($sformatf("row%0d oe_seen", i), 32'(oe_cnt != oe0), 32'(vecs[i].exp_ack));
            check($sformatf("row%0d final_state", i), 32'(dut.state), 32'h0);
            wait_q;
        end

        // Multi-byte write
        rx0 = rx_cnt;
        bus_start;
        write_byte(8'h96, ack);
        write_byte(8'h03, ack2);
        write_byte(8'hA5, ack3);
        bus_stop;
        check("write ack addr",  32'(ack),  32'h1);
        check("write ack b1",    32'(ack2), 32'h1);
        check("write ack b2",    32'(ack3), 32'h1);
        check("write rx count",  32'(rx_cnt - rx0), 32'd2);
        check("write rx first",  32'(rx_log[rx0]), 32'h03);
        check("write rx second", 32'(rx_log[rx0 + 1]), 32'hA5);
        check("write rx_data",   32'(rx_data), 32'hA5);
        wait_q;

        // STOP in the middle of a byte discards it
        rx0 = rx_cnt;
        bus_start;
        write_byte(8'h96, ack);
        clock_bit(1'b1, b1[0]);
        clock_bit(1'b0, b1[0]);
        clock_bit(1'b1, b1[0]);
        clock_bit(1'b0, b1[0]);
        bus_stop;
        check("partial ack",    32'(ack), 32'h1);
        check("partial no rx",  32'(rx_cnt - rx0), 32'd0);
        check("partial state",  32'(dut.state), 32'h0);
        check("partial sda_oe", 32'(sda_oe), 32'h0);
        wait_q;

        // Write followed by a repeated start and a read
        rx0 = rx_cnt;
        temp_data = 16'hBEEF;
        bus_start;
        write_byte(8'h96, ack);
        write_byte(8'h01, ack2);
        bus_start;
        write_byte(8'h97, ack3);
        read_byte(1'b1, -1, 16'h0, b1);
        read_byte(1'b0, -1, 16'h0, b2);
        bus_stop;
        check("rstart write ack", 32'(ack2), 32'h1);
        check("rstart rx",        32'(rx_log[rx0]), 32'h01);
        check("rstart addr ack",  32'(ack3), 32'h1);
        check("rstart byte1",     32'(b1), 32'hBE);
        check("rstart byte2",     32'(b2), 32'hEF);
        wait_q;

        // temp_data changes while byte 1 is on the wire
        temp_data = 16'h1234;
        bus_start;
        write_byte(8'h97, ack);
        read_byte(1'b1, 3, 16'hFFFF, b1);
        read_byte(1'b0, -1, 16'h0, b2);
        bus_stop;
        check("latch ack",   32'(ack), 32'h1);
        check("latch byte1", 32'(b1), 32'h12);
        check("latch byte2", 32'(b2), 32'h34);
        wait_q;

        // Reset while the target drives the address ACK
        bus_start;
        for (int i = 7; i >= 0; i--) begin
            b1 = 8'h96;
            clock_bit(b1[i], ack);
        end
        sda_m = 1'b1; wait_q;
        check("mid ack driven", 32'(sda_oe), 32'h1);
        scl_m = 1'b1; wait_q;
        @(negedge clk_100MHz) reset_n = 1'b0;
        @(posedge clk_100MHz) #1;
        check("mid reset sda_oe",  32'(sda_oe),  32'h0);
        check("mid reset busy",    32'(busy),    32'h0);
        check("mid reset rx_data", 32'(rx_data), 32'h0);
        repeat (2) @(negedge clk_100MHz);
        reset_n = 1'b1;
        wait_q;
        scl_m = 1'b0; wait_q;
        check("post reset idle", 32'(dut.state), 32'h0);
        temp_data = 16'h5AC3;
        bus_start;
        write_byte(8'h97, ack);
        read_byte(1'b1, -1, 16'h0, b1);
        read_byte(1'b0, -1, 16'h0, b2);
        bus_stop;
        check("post reset ack",   32'(ack), 32'h1);
        check("post reset byte1", 32'(b1), 32'h5A);
        check("post reset byte2", 32'(b2), 32'hC3);
        check("post reset state", 32'(dut.state), 32'h0);

        check("rx_valid one cycle", 32'(rx_long), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
